// File: rtl/bus_byte_loader_if.sv
// naive_bus: simple request/grant memory bus between loader masters and the on-chip RAM.
interface naive_bus;
    logic        rd_req;
    logic [31:0] rd_addr;
    logic        wr_req;
    logic        wr_gnt;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_be;

    modport master (output rd_req, rd_addr, wr_req, wr_addr, wr_data, wr_be, input wr_gnt);
    modport slave  (input rd_req, rd_addr, wr_req, wr_addr, wr_data, wr_be, output wr_gnt);
endinterface

// File: rtl/bus_byte_loader.sv
// Byte-stream loader: packs bytes little-endian into 32-bit words from a byte-granular
// base address and writes each completed or flushed word over naive_bus with byte enables.
module bus_byte_loader #(
    parameter logic [31:0] ADDR_LIMIT = 32'h0000_1000,
    parameter int          CNT_W      = 13
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic [31:0]      i_base_addr,
    input  logic             i_byte_valid,
    input  logic [7:0]       i_byte,
    output logic             o_byte_ready,
    input  logic             i_flush,
    output logic             o_busy,
    output logic             o_done,
    output logic [CNT_W-1:0] o_byte_cnt,
    output logic             o_err,
    naive_bus.master         bus
);

    typedef enum logic [1:0] {IDLE, COLLECT, WRITE} state_t;

    state_t           state, state_nxt;
    logic [29:0]      word_addr, word_addr_nxt;
    logic [1:0]       lane, lane_nxt;
    logic [3:0]       be_acc, be_nxt;
    logic [3:0][7:0]  data_acc, data_nxt;
    logic             end_pend, end_pend_nxt;
    logic             busy_nxt, done_nxt, err_nxt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             wr_req, wr_req_nxt;
    logic [31:0]      wr_addr, wr_addr_nxt;
    logic [31:0]      wr_data, wr_data_nxt;
    logic [3:0]       wr_be, wr_be_nxt;
    logic             byte_fire;
    logic             in_range;

    assign o_byte_ready = (state == COLLECT);
    assign byte_fire    = i_byte_valid && o_byte_ready;
    assign in_range     = {word_addr, 2'b00} < ADDR_LIMIT;

    assign bus.rd_req  = 1'b0;
    assign bus.rd_addr = 32'h0;
    assign bus.wr_req  = wr_req;
    assign bus.wr_addr = wr_addr;
    assign bus.wr_data = wr_data;
    assign bus.wr_be   = wr_be;

    always_comb begin
        state_nxt     = state;
        word_addr_nxt = word_addr;
        lane_nxt      = lane;
        be_nxt        = be_acc;
        data_nxt      = data_acc;
        end_pend_nxt  = end_pend;
        done_nxt      = 1'b0;
        err_nxt       = o_err;
        cnt_nxt       = o_byte_cnt;
        wr_req_nxt    = wr_req;
        wr_addr_nxt   = wr_addr;
        wr_data_nxt   = wr_data;
        wr_be_nxt     = wr_be;

        case (state)
            IDLE: begin
                if (i_start) begin
                    word_addr_nxt = i_base_addr[31:2];
                    lane_nxt      = i_base_addr[1:0];
                    be_nxt        = 4'h0;
                    data_nxt      = '0;
                    cnt_nxt       = '0;
                    err_nxt       = 1'b0;
                    end_pend_nxt  = 1'b0;
                    state_nxt     = COLLECT;
                end
            end
            COLLECT: begin
                if (byte_fire) begin
                    data_nxt[lane] = i_byte;
                    be_nxt[lane]   = 1'b1;
                    cnt_nxt        = o_byte_cnt + CNT_W'(1);
                end
                // be_nxt already includes a same-cycle byte, so byte+flush commits that word last
                if ((byte_fire && lane == 2'd3) || (i_flush && be_nxt != 4'h0)) begin
                    state_nxt    = WRITE;
                    end_pend_nxt = i_flush;
                    if (in_range) begin
                        wr_req_nxt  = 1'b1;
                        wr_addr_nxt = {word_addr, 2'b00};
                        wr_data_nxt = data_nxt;
                        wr_be_nxt   = be_nxt;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end else if (i_flush) begin
                    done_nxt  = 1'b1;
                    state_nxt = IDLE;
                end else if (byte_fire) begin
                    lane_nxt = lane + 2'd1;
                end
            end
            WRITE: begin
                // wr_req low here means the word was out of window and is dropped
                if (!wr_req || bus.wr_gnt) begin
                    wr_req_nxt    = 1'b0;
                    wr_be_nxt     = 4'h0;
                    word_addr_nxt = word_addr + 30'd1;
                    lane_nxt      = 2'd0;
                    be_nxt        = 4'h0;
                    data_nxt      = '0;
                    if (end_pend) begin
                        done_nxt  = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = COLLECT;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase

        busy_nxt = (state_nxt != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            word_addr  <= '0;
            lane       <= '0;
            be_acc     <= '0;
            data_acc   <= '0;
            end_pend   <= 1'b0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
            o_err      <= 1'b0;
            o_byte_cnt <= '0;
            wr_req     <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            wr_be      <= '0;
        end else begin
            state      <= state_nxt;
            word_addr  <= word_addr_nxt;
            lane       <= lane_nxt;
            be_acc     <= be_nxt;
            data_acc   <= data_nxt;
            end_pend   <= end_pend_nxt;
            o_busy     <= busy_nxt;
            o_done     <= done_nxt;
            o_err      <= err_nxt;
            o_byte_cnt <= cnt_nxt;
            wr_req     <= wr_req_nxt;
            wr_addr    <= wr_addr_nxt;
            wr_data    <= wr_data_nxt;
            wr_be      <= wr_be_nxt;
        end
    end

endmodule

// File: tb/tb_bus_byte_loader.sv
// Scoreboard bench for bus_byte_loader: a byte-address model predicts writes and done
// status per load; a negedge monitor pops and compares whenever the DUT shows them.
module tb_bus_byte_loader;
    localparam logic [31:0] LIMIT = 32'h0000_1000;
    localparam int          CNT_W = 13;

    logic             clk = 1'b0;
    logic             rst;
    logic             i_start, i_byte_valid, i_flush;
    logic [31:0]      i_base_addr;
    logic [7:0]       i_byte;
    logic             o_byte_ready, o_busy, o_done, o_err;
    logic [CNT_W-1:0] o_byte_cnt;
    logic             gnt_en;
    bit               auto_gnt;
    int               stall_pct;

    naive_bus bus_if();
    assign bus_if.wr_gnt = bus_if.wr_req & gnt_en;

    bus_byte_loader #(.ADDR_LIMIT(LIMIT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .i_start(i_start), .i_base_addr(i_base_addr),
        .i_byte_valid(i_byte_valid), .i_byte(i_byte), .o_byte_ready(o_byte_ready),
        .i_flush(i_flush), .o_busy(o_busy), .o_done(o_done), .o_byte_cnt(o_byte_cnt),
        .o_err(o_err), .bus(bus_if)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [31:0] addr; logic [31:0] data; logic [3:0] be; } wr_t;
    typedef struct packed { logic [CNT_W-1:0] cnt; logic err; } done_t;

    wr_t        wr_q[$];
    done_t      done_q[$];
    logic [7:0] stim[$];
    int         vectors = 0, miscompares = 0;
    int         writes_seen = 0, stall_cnt = 0;
    bit         prev_stall = 0;
    logic [67:0] prev_wr;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference: every byte i lives at byte address base+i; group by word, drop words past LIMIT.
    function automatic bit commit_word(input wr_t w);
        if (w.addr < LIMIT) begin
            wr_q.push_back(w);
            return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_load(input logic [31:0] base, input int n);
        wr_t         w;
        bit          open, err;
        logic [31:0] a;
        open = 0; err = 0; w = '0;
        for (int i = 0; i < n; i++) begin
            a = base + 32'(i);
            if (!open || a[31:2] != w.addr[31:2]) begin
                if (open) err |= commit_word(w);
                open = 1;
                w = '0;
                w.addr = {a[31:2], 2'b00};
            end
            w.data[8*a[1:0] +: 8] = stim[i];
            w.be[a[1:0]] = 1'b1;
        end
        if (open) err |= commit_word(w);
        done_q.push_back('{cnt: CNT_W'(n), err: err});
    endtask

    always @(posedge clk) begin
        #1;
        if (auto_gnt) gnt_en = (int'($urandom_range(99)) >= stall_pct);
    end

    always @(negedge clk) begin
        wr_t   e;
        done_t d;
        if (rst) begin
            prev_stall = 0;
        end else begin
            if (prev_stall) begin
                check("stall_hold", 96'({bus_if.wr_req, bus_if.wr_addr, bus_if.wr_data, bus_if.wr_be}),
                      96'({1'b1, prev_wr}));
                check("stall_ready", 96'(o_byte_ready), 96'(0));
            end
            if (bus_if.wr_req && bus_if.wr_gnt) begin
                writes_seen++;
                check("rd_req", 96'(bus_if.rd_req), 96'(0));
                if (wr_q.size() == 0) begin
                    vectors++; miscompares++;
                    $display("FAIL unexpected_write: got addr %0h data %0h be %0h, expected none",
                             bus_if.wr_addr, bus_if.wr_data, bus_if.wr_be);
                end else begin
                    e = wr_q.pop_front();
                    check("wr_word", 96'({bus_if.wr_addr, bus_if.wr_data, bus_if.wr_be}), 96'(e));
                end
            end
            if (bus_if.wr_req && !bus_if.wr_gnt) stall_cnt++;
            prev_stall = bus_if.wr_req && !bus_if.wr_gnt;
            prev_wr    = {bus_if.wr_addr, bus_if.wr_data, bus_if.wr_be};
            if (o_done) begin
                if (done_q.size() == 0) begin
                    vectors++; miscompares++;
                    $display("FAIL unexpected_done: got o_done=1, expected 0");
                end else begin
                    d = done_q.pop_front();
                    check("done_cnt_err", 96'({o_byte_cnt, o_err}), 96'(d));
                    check("done_busy", 96'(o_busy), 96'(0));
                end
            end
        end
    end

    task automatic start_load(input logic [31:0] base);
        i_start = 1; i_base_addr = base;
        @(posedge clk); #1;
        i_start = 0;
    endtask

    task automatic feed_bytes(input int n, input bit flush_last, input int valid_pct);
        int idx = 0, guard = 0;
        bit v, fire;
        while (idx < n && guard < 20 * n + 100) begin
            v = (int'($urandom_range(99)) < valid_pct);
            i_byte_valid = v; i_byte = stim[idx];
            i_flush = v && flush_last && (idx == n - 1);
            @(negedge clk); fire = v && o_byte_ready;
            @(posedge clk); #1; guard++;
            if (fire) idx++;
        end
        i_byte_valid = 0; i_flush = 0; i_byte = 0;
        check("feed_complete", 96'(idx), 96'(n));
    endtask

    task automatic do_flush();
        int guard = 0;
        bit fire = 0;
        i_flush = 1;
        while (!fire && guard < 200) begin
            @(negedge clk); fire = o_byte_ready;
            @(posedge clk); #1; guard++;
        end
        i_flush = 0;
        check("flush_taken", 96'(fire), 96'(1));
    endtask

    task automatic wait_quiet(input string tag);
        int g = 0;
        while ((wr_q.size() != 0 || done_q.size() != 0 || o_busy) && g < 2000) begin
            @(posedge clk); #1; g++;
        end
        vectors++;
        if (g >= 2000) begin
            miscompares++;
            $display("FAIL %s_drain: got %0d writes and %0d dones outstanding, expected 0",
                     tag, wr_q.size(), done_q.size());
            wr_q.delete(); done_q.delete();
        end
    endtask

    task automatic run_load(input logic [31:0] base, input int n, input bit flush_last, input int valid_pct);
        model_load(base, n);
        start_load(base);
        feed_bytes(n, flush_last && n > 0, valid_pct);
        if (!(flush_last && n > 0)) do_flush();
        wait_quiet("load");
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0, g;
        rst = 1; i_start = 0; i_base_addr = 0; i_byte_valid = 0; i_byte = 0; i_flush = 0;
        auto_gnt = 1; stall_pct = 0; gnt_en = 1;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        check("reset_outputs", 96'({o_byte_ready, o_busy, o_done, o_byte_cnt, o_err, bus_if.wr_req,
              bus_if.wr_be, bus_if.rd_req}), 96'(0));
        check("reset_wr_addr_data", 96'({bus_if.wr_addr, bus_if.wr_data}), 96'(0));
        @(posedge clk); #1;

        // Aligned load, flush after the last byte
        stim = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        w0 = writes_seen;
        run_load(32'h100, 8, 0, 100);
        check("aligned_writes", 96'(writes_seen - w0), 96'(2));

        // Misaligned base with flush alongside the last byte
        stim = '{8'hAA, 8'hBB, 8'hCC};
        w0 = writes_seen;
        run_load(32'h202, 3, 1, 100);
        check("misaligned_writes", 96'(writes_seen - w0), 96'(2));

        // Grant stall: three cycles of wr_gnt=0, grant on the fourth
        auto_gnt = 0; gnt_en = 0; stall_cnt = 0;
        stim = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        w0 = writes_seen;
        model_load(32'h300, 4);
        start_load(32'h300);
        feed_bytes(4, 0, 100);
        g = 0;
        while (!bus_if.wr_req && g < 20) begin @(negedge clk); g++; end
        check("stall_req_seen", 96'(bus_if.wr_req), 96'(1));
        repeat (2) begin @(posedge clk); #1; end
        @(posedge clk); #1 gnt_en = 1;
        @(posedge clk); #1 auto_gnt = 1;
        do_flush();
        wait_quiet("stall");
        check("stall_cycles", 96'(stall_cnt), 96'(3));
        check("stall_writes", 96'(writes_seen - w0), 96'(1));

        // Window limit: second word dropped and flagged, next start clears o_err
        stim = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        w0 = writes_seen;
        run_load(32'hFFC, 8, 0, 100);
        check("limit_writes", 96'(writes_seen - w0), 96'(1));
        check("limit_err_sticky", 96'(o_err), 96'(1));
        stim = '{8'h5A, 8'hA5};
        model_load(32'h10, 2);
        start_load(32'h10);
        @(negedge clk);
        check("start_clears_err", 96'(o_err), 96'(0));
        @(posedge clk); #1;
        feed_bytes(2, 1, 100);
        wait_quiet("limit_clear");

        // Empty flush with a same-cycle start that must be ignored
        w0 = writes_seen;
        model_load(32'h40, 0);
        start_load(32'h40);
        i_flush = 1; i_start = 1; i_base_addr = 32'h80;
        @(posedge clk); #1;
        i_flush = 0; i_start = 0;
        repeat (3) @(negedge clk);
        check("empty_idle", 96'({o_busy, o_byte_ready}), 96'(0));
        @(posedge clk); #1;
        wait_quiet("empty");
        check("empty_writes", 96'(writes_seen - w0), 96'(0));

        // Counter wraps modulo 2^CNT_W; upper words fall outside the window
        stim.delete();
        for (int i = 0; i < 8195; i++) stim.push_back(8'($urandom));
        run_load(32'h0, 8195, 0, 100);

        // Randomized loads with random bases, sizes, valid gaps and grant stalls
        for (int t = 0; t < 40; t++) begin
            logic [31:0] base;
            int n;
            base = 32'($urandom_range(32'h1100));
            n = int'($urandom_range(20));
            stim.delete();
            for (int i = 0; i < n; i++) stim.push_back(8'($urandom));
            stall_pct = int'($urandom_range(60));
            run_load(base, n, bit'($urandom_range(1)), 30 + int'($urandom_range(70)));
        end
        stall_pct = 0;
        @(posedge clk); #1;

        // Reset while a write is pending and ungranted
        auto_gnt = 0; gnt_en = 0;
        stim = '{8'h01, 8'h02, 8'h03, 8'h04};
        start_load(32'h100);
        feed_bytes(4, 0, 100);
        g = 0;
        while (!bus_if.wr_req && g < 20) begin @(negedge clk); g++; end
        check("rst_req_pending", 96'(bus_if.wr_req), 96'(1));
        @(posedge clk); #1 rst = 1;
        #1;
        check("rst_async_outputs", 96'({o_byte_ready, o_busy, o_done, o_byte_cnt, o_err, bus_if.wr_req,
              bus_if.wr_be}), 96'(0));
        check("rst_async_addr_data", 96'({bus_if.wr_addr, bus_if.wr_data}), 96'(0));
        wr_q.delete(); done_q.delete();
        @(posedge clk); #1 rst = 0;
        auto_gnt = 1;
        repeat (3) @(posedge clk);
        #1;
        stim = '{8'hC0, 8'hFF, 8'hEE, 8'h12, 8'h34};
        w0 = writes_seen;
        run_load(32'h121, 5, 1, 100);
        check("post_rst_writes", 96'(writes_seen - w0), 96'(2));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/bus_byte_loader.md
Name: bus_byte_loader

Overview:
- Upstream naive_bus master that feeds the on-chip RAM slave, used as a program/data loader.
- Accepts a byte stream with a valid/ready handshake.
- Packs bytes little-endian into 32-bit words, starting at a byte-granular base address.
- Issues one masked word write (wr_be) per completed or flushed word, and holds each write until wr_gnt.

Parameters:
- ADDR_LIMIT, 32'h0000_1000: first byte address outside the target window. Words at or above it are dropped and flagged.
- CNT_W, 13: width of the accepted-byte counter.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- i_start  input  1  single-cycle pulse. Latches i_base_addr and begins a load.
- i_base_addr  input  32  byte address of the first stream byte. Any alignment is allowed.
- i_byte_valid  input  1  stream byte valid.
- i_byte  input  8  stream byte.
- o_byte_ready  output  1  loader can accept i_byte this cycle.
- i_flush  input  1  end of stream. Commits any partial word, then finishes.
- o_busy  output  1  load in progress.
- o_done  output  1  single-cycle pulse when the load completes.
- o_byte_cnt  output  CNT_W  bytes accepted since the last i_start.
- o_err  output  1  sticky. A word fell at or above ADDR_LIMIT; cleared by i_start.
- bus  naive_bus.master  -  master side of naive_bus. Drives rd_req=0, rd_addr=0, wr_req, wr_addr, wr_data, wr_be. Samples wr_gnt.

Behaviour:
- Reset values:
  - state=IDLE.
  - o_byte_ready=0, o_busy=0, o_done=0, o_byte_cnt=0, o_err=0.
  - wr_req=0, wr_addr=0, wr_data=0, wr_be=0.
  - Internal word_addr=0, lane=0, be_acc=0, data_acc=0, end_pend=0.
- The FSM has three states: IDLE, COLLECT, WRITE. All outputs are registered except o_byte_ready, which is decoded from state.
- IDLE:
  - o_byte_ready=0, o_busy=0.
  - On i_start: word_addr=i_base_addr[31:2], lane=i_base_addr[1:0], be_acc=0, data_acc=0, o_byte_cnt=0, o_err=0, end_pend=0. Go to COLLECT.
  - i_flush and i_byte_valid are ignored.
- COLLECT:
  - o_byte_ready=1, o_busy=1.
  - On i_byte_valid & o_byte_ready:
    - data_acc[lane*8+:8]=i_byte, be_acc[lane]=1, o_byte_cnt+1. The counter wraps modulo 2^CNT_W, with no flag.
    - If lane==3, go to WRITE. Otherwise lane+1.
  - On i_flush with be_acc (including the same-cycle byte) nonzero: end_pend=1, go to WRITE.
  - On i_flush with be_acc zero and no same-cycle byte: pulse o_done next cycle, go to IDLE.
  - Byte and flush in the same cycle: the byte is accepted first, then that word is written as the final one.
- WRITE:
  - o_byte_ready=0, o_busy=1.
  - If {word_addr,2'b00} < ADDR_LIMIT:
    - wr_req=1, wr_addr={word_addr,2'b00}, wr_data=data_acc, wr_be=be_acc.
    - All four are held stable until the cycle wr_gnt=1.
  - Otherwise: no wr_req, o_err=1, and the word is treated as granted immediately.
  - On grant or drop:
    - wr_req=0, wr_be=0, word_addr+1 (wraps at 2^30), lane=0, be_acc=0, data_acc=0.
    - If end_pend, pulse o_done and go to IDLE. Otherwise go to COLLECT.
- Latency with the RAM slave (wr_gnt=wr_req):
  - The word write is visible on the bus the cycle after its 4th byte is accepted.
  - A gap of one cycle with ready low follows each full word.
  - Steady-state throughput is 4 bytes per 5 cycles.
- i_start while o_busy=1 is ignored.
- i_flush in WRITE is ignored unless end_pend is already set.
- A misaligned base writes a partial first word.
  - Example: base[1:0]=2 gives first wr_be=4'b1100.
- Reset asserted mid-operation:
  - All state clears immediately (asynchronously), and wr_req drops in the same cycle.
  - No o_done is produced.
  - A word that was pending but not granted is lost.
- rd_req is never asserted.

Test Plan:
- Aligned load: start base=0x100, bytes 11,22,33,44,55,66,77,88, then flush. Expect:
  - wr 0x100 data 0x44332211 be 4'hF.
  - wr 0x104 data 0x88776655 be 4'hF.
  - No third write. o_done one cycle after flush. o_byte_cnt=8.
- Misaligned partial: base=0x202, bytes AA,BB,CC, flush in the same cycle as CC. Expect:
  - wr 0x200 data 0xBBAA0000 be 4'hC.
  - wr 0x204 data 0x000000CC be 4'h1.
  - Then o_done. o_byte_cnt=3.
- Grant stall: slave holds wr_gnt=0 for 3 cycles after one full word. Expect:
  - wr_req, addr, data and be stable for 4 cycles.
  - o_byte_ready=0 throughout the stall.
  - Exactly one write is accepted.
- Limit error: base=0xFFC, bytes 01..08, flush. Expect:
  - wr 0xFFC data 0x04030201 be 4'hF.
  - The second word produces no wr_req, and o_err=1.
  - o_done pulses. A new i_start clears o_err.
- Empty flush and ignored start: start, then flush with no bytes gives o_done with zero writes. An i_start in the same cycle as that flush is ignored; after the pulse, state is IDLE.
- Reset mid-load: assert rst while wr_req=1 and wr_gnt=0. Expect:
  - wr_req=0 immediately, and all outputs are at reset values.
  - No o_done.
  - A fresh start after reset loads correctly.
